// File: rtl/key_event_fifo.sv
// Keypad row-report decoder feeding a first-word-fall-through key-code FIFO.
// Optional `KEY_IRQ_EN adds a registered fill-level / overflow interrupt output.
module key_event_fifo #(
   parameter int DEPTH      = 8,
   parameter int AW         = 3,
   parameter int IRQ_THRESH = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          row_rdy,
   input  logic [1:0]    hi,
   input  logic [3:0]    col_n,
   input  logic          rd_en,
   input  logic          ovf_clr,
   output logic [3:0]    key_code,
   output logic          key_valid,
   output logic [AW:0]   fifo_cnt,
   output logic          busy,
   output logic          ovf
`ifdef KEY_IRQ_EN
   ,
   output logic          irq
`endif
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   if (DEPTH != (1 << AW) || IRQ_THRESH < 0 || IRQ_THRESH > DEPTH) begin : g_bad_param
      $error("key_event_fifo: inconsistent DEPTH/AW/IRQ_THRESH");
   end

   typedef enum logic {IDLE, SCAN} state_t;

   state_t        state, state_nxt;
   logic [1:0]    row_p1;
   logic [3:0]    mask_p1;
   logic [1:0]    idx_p1;
   logic          latch_rpt;
   logic          vld_p1;
   logic          drop_rpt;

   logic [3:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          full, pop, wr, drop_key;

   always_comb begin
      state_nxt = state;
      latch_rpt = 1'b0;
      vld_p1    = 1'b0;
      drop_rpt  = 1'b0;
      case (state)
         IDLE: begin
            if (row_rdy && (~col_n != 4'h0)) begin
               latch_rpt = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            vld_p1   = mask_p1[idx_p1];
            drop_rpt = row_rdy;
            if (idx_p1 == 2'd3)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // stage p1: latched report, one column visited per clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         idx_p1 <= 2'd0;
      end else begin
         state  <= state_nxt;
         idx_p1 <= (state == SCAN) ? idx_p1 + 2'd1 : 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (latch_rpt) begin
         row_p1  <= hi;
         mask_p1 <= ~col_n;
      end
   end

   assign busy     = (state == SCAN);
   assign full     = (fifo_cnt == FULL_CNT);
   assign pop      = rd_en && (fifo_cnt != '0);
   // A full FIFO still accepts a push when the head is popped in the same cycle.
   assign wr       = vld_p1 && (!full || pop);
   assign drop_key = vld_p1 && full && !pop;

   // stage p2: FIFO storage and bookkeeping
   always_ff @(posedge clk) begin
      if (wr)
         mem[wr_ptr] <= {row_p1, idx_p1};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         if (wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
         if (drop_key || drop_rpt)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

   assign key_valid = (fifo_cnt != '0);
   assign key_code  = key_valid ? mem[rd_ptr] : 4'h0;

`ifdef KEY_IRQ_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         irq <= 1'b0;
      else
         irq <= (fifo_cnt >= (AW+1)'(IRQ_THRESH)) || ovf;
   end
`endif

endmodule
